// File: rtl/vga_frame_reader.sv
// Scans a 640x480 RGB565 frame buffer out as 640x480@60 VGA on clk25.
// Raster counters drive RAM reads; a 3-stage pipeline keeps syncs and pixels aligned.
module vga_frame_reader #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic        clk25,
  input  logic        reset,
  input  logic        testPattern,
  output logic [18:0] readAddr,
  output logic        readEn,
  input  logic [15:0] readData,
  output logic [3:0]  vgaR,
  output logic [3:0]  vgaG,
  output logic [3:0]  vgaB,
  output logic        vgaHS,
  output logic        vgaVS,
  output logic        frameStart
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_VIS     = 10'(H_VISIBLE);
  localparam logic [9:0]  V_VIS     = 10'(V_VISIBLE);
  localparam logic [9:0]  HS_START  = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0]  HS_END    = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0]  VS_START  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]  VS_END    = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [18:0] ADDR_LAST = 19'(H_VISIBLE * V_VISIBLE - 1);
  localparam logic [9:0]  BAR_W     = 10'd80;

  function automatic logic [11:0] bar_color(input logic [2:0] bar);
    case (bar)
      3'd0:    bar_color = 12'hFFF;
      3'd1:    bar_color = 12'hFF0;
      3'd2:    bar_color = 12'h0FF;
      3'd3:    bar_color = 12'h0F0;
      3'd4:    bar_color = 12'hF0F;
      3'd5:    bar_color = 12'hF00;
      3'd6:    bar_color = 12'h00F;
      default: bar_color = 12'h000;
    endcase
  endfunction

  function automatic logic [11:0] rgb565_to_444(input logic [15:0] px);
    return {px[15:12], px[10:7], px[4:1]};
  endfunction

  logic [9:0]  h_cnt, v_cnt;
  logic [18:0] addr_cnt;
  logic        h_wrap, v_wrap, visible, hs_raw, vs_raw, origin;

  assign h_wrap  = (h_cnt == H_LAST);
  assign v_wrap  = (v_cnt == V_LAST);
  assign visible = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign hs_raw  = !((h_cnt >= HS_START) && (h_cnt < HS_END));
  assign vs_raw  = !((v_cnt >= VS_START) && (v_cnt < VS_END));
  assign origin  = (h_cnt == 10'd0) && (v_cnt == 10'd0);

  // The address tracks the raster so no y*640 multiply is needed; it wraps
  // after the last visible pixel so blanking never presents an out-of-range address.
  always_ff @(posedge clk25) begin
    if (reset) begin
      h_cnt    <= 10'd0;
      v_cnt    <= 10'd0;
      addr_cnt <= 19'd0;
    end else begin
      h_cnt <= h_wrap ? 10'd0 : h_cnt + 10'd1;
      if (h_wrap)
        v_cnt <= v_wrap ? 10'd0 : v_cnt + 10'd1;
      if (h_wrap && v_wrap)
        addr_cnt <= 19'd0;
      else if (visible)
        addr_cnt <= (addr_cnt == ADDR_LAST) ? 19'd0 : addr_cnt + 19'd1;
    end
  end

  // Stage 1: read request issued, pixel attributes launched alongside it
  logic       vld_p1, hs_p1, vs_p1, org_p1, tp_p1;
  logic [2:0] bar_p1;

  always_ff @(posedge clk25) begin
    if (reset) begin
      readAddr <= 19'd0;
      vld_p1   <= 1'b0;
      hs_p1    <= 1'b1;
      vs_p1    <= 1'b1;
      org_p1   <= 1'b0;
    end else begin
      readAddr <= addr_cnt;
      vld_p1   <= visible;
      hs_p1    <= hs_raw;
      vs_p1    <= vs_raw;
      org_p1   <= origin;
    end
  end

  always_ff @(posedge clk25) begin
    bar_p1 <= 3'(h_cnt / BAR_W);
    tp_p1  <= testPattern;
  end

  assign readEn = vld_p1;

  // Stage 2: RAM access in flight, attributes wait one cycle for readData
  logic       vld_p2, hs_p2, vs_p2, org_p2, tp_p2;
  logic [2:0] bar_p2;

  always_ff @(posedge clk25) begin
    if (reset) begin
      vld_p2 <= 1'b0;
      hs_p2  <= 1'b1;
      vs_p2  <= 1'b1;
      org_p2 <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      hs_p2  <= hs_p1;
      vs_p2  <= vs_p1;
      org_p2 <= org_p1;
    end
  end

  always_ff @(posedge clk25) begin
    bar_p2 <= bar_p1;
    tp_p2  <= tp_p1;
  end

  // Stage 3: colour select and registered pins
  logic [11:0] pixel_rgb;

  always_comb begin
    pixel_rgb = 12'h000;
    if (vld_p2)
      pixel_rgb = tp_p2 ? bar_color(bar_p2) : rgb565_to_444(readData);
  end

  always_ff @(posedge clk25) begin
    if (reset) begin
      vgaR       <= 4'h0;
      vgaG       <= 4'h0;
      vgaB       <= 4'h0;
      vgaHS      <= 1'b1;
      vgaVS      <= 1'b1;
      frameStart <= 1'b0;
    end else begin
      {vgaR, vgaG, vgaB} <= pixel_rgb;
      vgaHS              <= hs_p2;
      vgaVS              <= vs_p2;
      frameStart         <= org_p2;
    end
  end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader with a shortened vertical frame; a raster reference
// model predicts every output from the cycle count since reset.
module tb_vga_frame_reader;

  localparam int HV = 640, HF = 16, HS = 96, HB = 48;
  localparam int VV = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int LAST = HV * VV - 1;
  localparam logic [11:0] BARS [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                       12'hF0F, 12'hF00, 12'h00F, 12'h000};

  logic        clk25 = 1'b0;
  logic        reset = 1'b1;
  logic        testPattern = 1'b0;
  logic [18:0] readAddr;
  logic        readEn;
  logic [15:0] readData;
  logic [3:0]  vgaR, vgaG, vgaB;
  logic        vgaHS, vgaVS, frameStart;

  vga_frame_reader #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk25(clk25), .reset(reset), .testPattern(testPattern),
    .readAddr(readAddr), .readEn(readEn), .readData(readData),
    .vgaR(vgaR), .vgaG(vgaG), .vgaB(vgaB),
    .vgaHS(vgaHS), .vgaVS(vgaVS), .frameStart(frameStart)
  );

  always #20 clk25 = ~clk25;

  // RAM: 1-cycle latency, content = address XOR salt, all-ones when not read
  logic [15:0] salt = 16'h0000;
  always @(posedge clk25) readData <= readEn ? (readAddr[15:0] ^ salt) : 16'hFFFF;

  int checks = 0;
  int errors = 0;
  int n = 0;
  bit tp_hist [0:32767];

  typedef struct packed {
    logic        en;
    logic [18:0] addr;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        fs;
  } exp_t;

  function automatic logic [11:0] px444(input logic [15:0] d);
    return {d[15:12], d[10:7], d[4:1]};
  endfunction

  // Expected outputs after the cyc-th edge since reset: request side shows
  // raster position cyc-1, pins show position cyc-3.
  function automatic exp_t model(input int cyc);
    exp_t e;
    int p, h, v;
    e = '{en: 1'b0, addr: 19'd0, rgb: 12'h000, hs: 1'b1, vs: 1'b1, fs: 1'b0};
    if (cyc >= 1) begin
      p = cyc - 1; h = p % HT; v = (p / HT) % VT;
      e.en = (h < HV) && (v < VV);
      if (e.en) e.addr = 19'(v * HV + h);
    end
    if (cyc >= 3) begin
      p = cyc - 3; h = p % HT; v = (p / HT) % VT;
      e.hs = !(h >= HV + HF && h < HV + HF + HS);
      e.vs = !(v >= VV + VF && v < VV + VF + VS);
      e.fs = (p % FT) == 0;
      if (h < HV && v < VV)
        e.rgb = tp_hist[p] ? BARS[h / 80] : px444(16'(v * HV + h) ^ salt);
    end
    return e;
  endfunction

  task automatic tick(input bit tp);
    testPattern = tp;
    tp_hist[n] = tp;
    @(posedge clk25);
    n++;
    @(negedge clk25);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    testPattern = 1'b0;
    @(posedge clk25);
    @(negedge clk25);
    reset = 1'b0;
    n = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      testPattern = 1'($urandom);
      @(posedge clk25);
      @(negedge clk25);
      checks++;
      if ({readEn, readAddr, vgaR, vgaG, vgaB, vgaHS, vgaVS, frameStart} !==
          {1'b0, 19'd0, 12'h000, 1'b1, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL reset_hold cyc %0d got en=%b addr=%0d rgb=%h hs=%b vs=%b fs=%b want all idle",
                 i, readEn, readAddr, {vgaR, vgaG, vgaB}, vgaHS, vgaVS, frameStart);
      end
    end
    reset = 1'b0;
    n = 0;
  endtask

  task automatic test_free_run();
    exp_t e;
    logic [34:0] obs;
    int en_cnt = 0, prev_addr = -1, fs_last = -1, fs_cnt = 0;
    int hs_len = 0, hs_fall = -1, vs_len = 0, vs_fall = -1;
    logic hs_q = 1'b1, vs_q = 1'b1;
    salt = 16'h0000;
    do_reset();
    for (int i = 0; i < 2 * FT + 8; i++) begin
      tick(1'b0);
      e = model(n);
      obs = {readEn, (e.en || n == 0) ? readAddr : 19'd0, vgaR, vgaG, vgaB, vgaHS, vgaVS, frameStart};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL free_run cyc %0d got %h want %h", n, obs, e);
      end
      if (n <= FT && readEn) en_cnt++;
      if (readEn) begin
        if (prev_addr >= 0) begin
          checks++;
          if (int'(readAddr) != ((prev_addr == LAST) ? 0 : prev_addr + 1)) begin
            errors++;
            $display("FAIL addr_seq cyc %0d got %0d after %0d", n, readAddr, prev_addr);
          end
        end
        prev_addr = int'(readAddr);
      end
      if (!vgaHS) hs_len++;
      if (hs_q && !vgaHS) begin
        if (hs_fall >= 0) begin
          checks++;
          if (n - hs_fall != HT) begin
            errors++;
            $display("FAIL hs_period got %0d want %0d", n - hs_fall, HT);
          end
        end
        hs_fall = n;
      end
      if (!hs_q && vgaHS) begin
        checks++;
        if (hs_len != HS) begin
          errors++;
          $display("FAIL hs_width got %0d want %0d", hs_len, HS);
        end
        hs_len = 0;
      end
      if (!vgaVS) vs_len++;
      if (vs_q && !vgaVS) begin
        if (vs_fall >= 0) begin
          checks++;
          if (n - vs_fall != FT) begin
            errors++;
            $display("FAIL vs_period got %0d want %0d", n - vs_fall, FT);
          end
        end
        vs_fall = n;
      end
      if (!vs_q && vgaVS) begin
        checks++;
        if (vs_len != VS * HT) begin
          errors++;
          $display("FAIL vs_width got %0d want %0d", vs_len, VS * HT);
        end
        vs_len = 0;
      end
      if (frameStart) begin
        fs_cnt++;
        if (fs_last >= 0) begin
          checks++;
          if (n - fs_last != FT) begin
            errors++;
            $display("FAIL fs_period got %0d want %0d", n - fs_last, FT);
          end
        end
        fs_last = n;
      end
      if (n - 3 == 2 * HT + 5) begin
        checks++;
        if ({vgaR, vgaG, vgaB} !== 12'h0A2) begin
          errors++;
          $display("FAIL pixel_5_2 got %h want 0a2", {vgaR, vgaG, vgaB});
        end
      end
      hs_q = vgaHS;
      vs_q = vgaVS;
    end
    checks++;
    if (en_cnt != HV * VV) begin
      errors++;
      $display("FAIL readEn_count got %0d want %0d", en_cnt, HV * VV);
    end
    checks++;
    if (fs_cnt != 3) begin
      errors++;
      $display("FAIL fs_count got %0d want 3", fs_cnt);
    end
  endtask

  task automatic test_pattern();
    exp_t e;
    logic [34:0] obs;
    int p;
    salt = 16'($urandom);
    do_reset();
    for (int i = 0; i < FT + 4; i++) begin
      tick(1'b1);
      e = model(n);
      obs = {readEn, (e.en || n == 0) ? readAddr : 19'd0, vgaR, vgaG, vgaB, vgaHS, vgaVS, frameStart};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL pattern cyc %0d got %h want %h", n, obs, e);
      end
      p = n - 3;
      if (p == 0 || p == 79 || p == 80 || p == 639 || p == HT + 560 || p == 700) begin
        checks++;
        if ({vgaR, vgaG, vgaB} !== ((p == 0 || p == 79) ? 12'hFFF : (p == 80) ? 12'hFF0 : 12'h000)) begin
          errors++;
          $display("FAIL bar_pixel pos %0d got %h", p, {vgaR, vgaG, vgaB});
        end
      end
    end
  endtask

  task automatic test_tp_toggle();
    exp_t e;
    logic [34:0] obs;
    int h, v;
    bit flip = 1'b0;
    salt = 16'($urandom);
    do_reset();
    for (int i = 0; i < FT + FT / 2; i++) begin
      h = n % HT;
      v = (n / HT) % VT;
      if (h == 0) flip = (v == 0) ? 1'b0 : 1'($urandom);
      if (i < FT) tick(1'(h >= 320) ^ flip);
      else tick(1'($urandom));
      e = model(n);
      obs = {readEn, (e.en || n == 0) ? readAddr : 19'd0, vgaR, vgaG, vgaB, vgaHS, vgaVS, frameStart};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL tp_toggle cyc %0d got %h want %h", n, obs, e);
      end
      if (n - 3 == 319) begin
        checks++;
        if ({vgaR, vgaG, vgaB} !== px444(16'(319) ^ salt)) begin
          errors++;
          $display("FAIL tp_edge_319 got %h want %h", {vgaR, vgaG, vgaB}, px444(16'(319) ^ salt));
        end
      end
      if (n - 3 == 320) begin
        checks++;
        if ({vgaR, vgaG, vgaB} !== 12'hF0F) begin
          errors++;
          $display("FAIL tp_edge_320 got %h want f0f", {vgaR, vgaG, vgaB});
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    logic [34:0] obs;
    salt = 16'($urandom);
    do_reset();
    while (n < 2 * HT + 300) begin
      tick(1'($urandom));
      e = model(n);
      obs = {readEn, (e.en || n == 0) ? readAddr : 19'd0, vgaR, vgaG, vgaB, vgaHS, vgaVS, frameStart};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL pre_reset cyc %0d got %h want %h", n, obs, e);
      end
    end
    reset = 1'b1;
    @(posedge clk25);
    @(negedge clk25);
    reset = 1'b0;
    n = 0;
    checks++;
    if ({readEn, readAddr, vgaR, vgaG, vgaB, vgaHS, vgaVS, frameStart} !==
        {1'b0, 19'd0, 12'h000, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset got en=%b addr=%0d rgb=%h hs=%b vs=%b fs=%b want all idle",
               readEn, readAddr, {vgaR, vgaG, vgaB}, vgaHS, vgaVS, frameStart);
    end
    for (int i = 0; i < FT + 8; i++) begin
      tick(1'($urandom));
      e = model(n);
      obs = {readEn, (e.en || n == 0) ? readAddr : 19'd0, vgaR, vgaG, vgaB, vgaHS, vgaVS, frameStart};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL post_reset cyc %0d got %h want %h", n, obs, e);
      end
      if (n == 1) begin
        checks++;
        if ({readEn, readAddr} !== {1'b1, 19'd0}) begin
          errors++;
          $display("FAIL first_read got en=%b addr=%0d want en=1 addr=0", readEn, readAddr);
        end
      end
      if (n <= 3) begin
        checks++;
        if (frameStart !== (n == 3)) begin
          errors++;
          $display("FAIL first_fs cyc %0d got %b want %b", n, frameStart, n == 3);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_pattern();
    test_tp_toggle();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_frame_reader.md
# vga_frame_reader

Reads the 640x480 RGB565 frame buffer that the camera capture path fills, and scans it out as 640x480@60 Hz VGA. It is the consumer side of the frame-buffer RAM: it issues read addresses on the RAM's second port in raster order, converts returned pixels to 4:4:4 RGB, and drives sync-aligned VGA pins. It runs in the same 25 MHz domain that clocks the camera XCLK.

## Interface
Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16; H_SYNC, 96; H_BACK, 48: horizontal porches/sync in clocks (line total 800)
- V_VISIBLE, 480, active lines
- V_FRONT, 10; V_SYNC, 2; V_BACK, 33: vertical porches/sync in lines (frame total 525)

Ports:
- clk25  input  1  pixel clock, all logic on rising edge
- reset  input  1  synchronous, active-high
- testPattern  input  1  1 = color bars instead of RAM data, sampled per pixel
- readAddr  output  19  frame-buffer read address, y*640+x
- readEn  output  1  read strobe, high for visible pixels only
- readData  input  16  RGB565 from RAM, valid exactly 1 clock after readAddr/readEn
- vgaR, vgaG, vgaB  output  4 each  color to DAC
- vgaHS, vgaVS  output  1 each  syncs, active-low
- frameStart  output  1  one-clock pulse aligned with pixel (0,0) on the pins

## Operation
- Counters hCount 0..799, vCount 0..524. hCount wraps 799->0 and increments vCount; vCount wraps 524->0 on same edge as hCount wrap.
- visible = hCount<640 && vCount<480. hsyncRaw low for hCount 656..751; vsyncRaw low for vCount 490..491.
- Address: incremental counter, no multiplier. Increments by 1 on each visible cycle; reset to 0 when counters wrap to (799,524)->(0,0). Last address 307199, then 0. Must never exceed 307199.
- Pipeline stage 1 (registered): readAddr, readEn=visible, plus visible/hsync/vsync/hCount bar index/origin flag delayed.
- Stage 2: RAM returns readData.
- Stage 3 (registered pins): if !visible_d2 -> RGB=0. Else if testPattern_d2 -> bar color. Else R=readData[15:12], G=readData[10:7], B=readData[4:1]. vgaHS/vgaVS/frameStart registered from 2-stage-delayed raw values.
- Color bars: bar = x/80 (0..7): white F/F/F, yellow F/F/0, cyan 0/F/F, green 0/F/0, magenta F/0/F, red F/0/0, blue 0/0/F, black 0/0/0.
- testPattern travels down the pipeline with its pixel; toggling mid-line switches at that pixel.
- readData is ignored whenever the delayed visible flag is 0.

## Timing
- Latency: counter state at cycle t -> readAddr/readEn at t+1 -> readData at t+2 -> pins at t+3. Syncs, frameStart and RGB all carry the same 3-cycle delay; relative sync/pixel alignment is identical to raw counters.
- Reset values (cycle after reset sampled high): hCount=0, vCount=0, readAddr=0, readEn=0, vgaR/G/B=0, vgaHS=1, vgaVS=1, frameStart=0; all pipeline valid/sync flags cleared to blank/inactive.
- Reset mid-frame: pins go blank and syncs inactive on the next edge; no partial pulse after release; first readEn in the 1st cycle after reset deasserts, with readAddr=0; frameStart fires 3 cycles after counters first sit at (0,0).
- Reset held: all outputs remain at reset values.
- readEn high exactly 640 cycles per visible line, 307200 per frame; 0 during blanking.
- hsync pulse 96 clocks every 800; vsync pulse 1600 clocks every 420000.

## Test plan
- Reset then free-run 2 frames -> vgaHS low 96 clocks per 800-clock period, vgaVS low 1600 clocks per 420000; frameStart period 420000 clocks.
- RAM model returns readData = readAddr[15:0] with 1-cycle latency -> pixel on pins at (x=5,y=2) shows data of addr 1285: R=0x0, G=0xA, B=0x2; 3-cycle alignment verified against counters.
- Address sweep -> readAddr sequence 0..307199 with no gaps/repeats, then 0 at next frame; readEn count per frame = 307200.
- testPattern=1 -> pixels x=0..79 F/F/F, x=80 F/F/0, x=560..639 0/0/0; blanking pins 0 even if readData=0xFFFF.
- Assert reset for 1 cycle at (hCount=300,vCount=200) -> next cycle all outputs at reset values; after release readAddr=0 with readEn=1, frameStart 3 cycles after counters reach (0,0).
- Toggle testPattern at x=320 mid-line -> pins switch source exactly at pixel 320, no 1-pixel skew.
